exti_mc: RTL and testbench

//  Multi-channel external interrupt controller. Memory-mapped slave on arilla_bus_if.

---
 rtl/exti_mc_if.sv | 23 ++
 rtl/exti_mc.sv | 152 +++++++++++++++
 tb/tb_exti_mc.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exti_mc_if.sv
// arilla_bus_if: single-beat valid/ready bus.
// Read data returns one clock after the accepted request.
interface arilla_bus_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic            we;
  logic [31:0]     addr;
  logic [XLEN-1:0] wdata;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/exti_mc.sv
// exti_mc: multi-channel external interrupt controller on arilla_bus_if.
// Optional per-pin debounce filter: define EXTI_MC_DEBOUNCE_EN.
module exti_mc #(
  parameter logic [31:0] BaseAddress = 32'h0,
  parameter int          NumIO       = 12,
  parameter int          SyncStages  = 2,
  parameter int          DebounceLen = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NumIO-1:0] pins,
  output logic             intr,
  arilla_bus_if.slave      bus_interface
);
  localparam int XLEN = 32;
`ifdef EXTI_MC_DEBOUNCE_EN
  // priming must also cover the debounce fill after reset
  localparam int ArmLen = SyncStages + 1 + DebounceLen;
`else
  localparam int ArmLen = SyncStages + 1;
`endif
  localparam int AW = $clog2(ArmLen + 1);

  logic [NumIO-1:0] ie_q, rise_q, fall_q, lvl_q, pend_q;
  logic [NumIO-1:0] sync_q [SyncStages];
  logic [NumIO-1:0] s, db, p_q;
  logic [NumIO-1:0] rise, fall, set, act, w1c, wd;
  logic [AW-1:0]    arm_cnt_q;
  logic             armed;
  logic [5:0]       id;
  logic [2:0]       off;
  logic             sel, wr_en;
  logic [XLEN-1:0]  rmux, rdata_q;
  logic             rvalid_q, intr_q;
  logic             unused_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SyncStages-1];

`ifdef EXTI_MC_DEBOUNCE_EN
  logic [7:0]       db_cnt_q [NumIO];
  logic [NumIO-1:0] db_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < NumIO; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumIO; i++) begin
        if (s[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == 8'(DebounceLen - 1)) begin
          db_q[i]     <= s[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign db = db_q;
`else
  assign db = s;
`endif

  assign armed = (arm_cnt_q == AW'(ArmLen));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_cnt_q <= '0;
      p_q       <= '0;
    end else begin
      if (!armed) arm_cnt_q <= arm_cnt_q + AW'(1);
      p_q <= db;
    end
  end

  assign rise = db & ~p_q & {NumIO{armed}};
  assign fall = ~db & p_q & {NumIO{armed}};
  assign set  = (rise_q & rise) | (fall_q & fall) | (lvl_q & s);
  assign act  = pend_q & ie_q;

  always_comb begin
    id = '0;
    for (int i = NumIO - 1; i >= 0; i--) begin
      if (act[i]) id = 6'(i + 1);
    end
  end

  assign off   = bus_interface.addr[4:2];
  assign sel   = (bus_interface.addr[31:5] == BaseAddress[31:5]);
  assign wr_en = bus_interface.valid & bus_interface.we & sel;
  assign wd    = bus_interface.wdata[NumIO-1:0];
  assign w1c   = (wr_en && off == 3'd4) ? wd : '0;

  always_comb begin
    rmux = '0;
    case (off)
      3'd0:    rmux = XLEN'(ie_q);
      3'd1:    rmux = XLEN'(rise_q);
      3'd2:    rmux = XLEN'(fall_q);
      3'd3:    rmux = XLEN'(lvl_q);
      3'd4:    rmux = XLEN'(pend_q);
      3'd5:    rmux = XLEN'(db);
      3'd6:    rmux = XLEN'(id);
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      lvl_q    <= '0;
      pend_q   <= '0;
      intr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // a set in the same cycle beats the W1C clear
      pend_q   <= (pend_q & ~w1c) | set;
      intr_q   <= |act;
      rvalid_q <= bus_interface.valid & ~bus_interface.we;
      rdata_q  <= sel ? rmux : '0;
      if (wr_en) begin
        case (off)
          3'd0:    ie_q   <= wd;
          3'd1:    rise_q <= wd;
          3'd2:    fall_q <= wd;
          3'd3:    lvl_q  <= wd;
          default: ;
        endcase
      end
    end
  end

  assign intr                 = intr_q;
  assign bus_interface.ready  = 1'b1;
  assign bus_interface.rvalid = rvalid_q;
  assign bus_interface.rdata  = rdata_q;
  assign unused_bits = ^{bus_interface.addr[1:0], bus_interface.wdata};
endmodule

// File: tb/tb_exti_mc.sv
// tb_exti_mc: randomized scoreboard bench for exti_mc.
// Build with EXTI_MC_DEBOUNCE_EN to cover the debounce filter.
module tb_exti_mc;
  localparam int N  = 12;
  localparam int SS = 2;
  localparam int DL = 4;
`ifdef EXTI_MC_DEBOUNCE_EN
  localparam int ARM = SS + 1 + DL;
  localparam int LAT = SS + DL;
`else
  localparam int ARM = SS + 1;
  localparam int LAT = SS;
`endif
  localparam logic [31:0] MASK = 32'h0000_0FFF;

  typedef struct {
    logic [31:0] val;
    int          off;
    string       tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pins;
  logic         intr;
  bit           go = 1'b0;

  arilla_bus_if bus ();

  exti_mc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pins          (pins),
    .intr          (intr),
    .bus_interface (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  exp_t        q[$];
  bit          fix_en;
  logic [31:0] fix_val;
  string       fix_tag;

  logic [31:0] m_ie, m_rise, m_fall, m_lvl, m_pend, m_db, m_p;
  logic        m_intr;
  int          m_cyc;
  int          m_run[N];
  logic [31:0] ph[$];

  function automatic logic [31:0] low_id(logic [31:0] a);
    for (int i = 0; i < 32; i++) if (a[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  // reference model: s is simply the pin value SS clocks ago
  always @(posedge clk) begin : model
    logic [31:0] s, db, rs, fl, st, w1c, rv, act;
    exp_t        e;
    if (!rst_n) begin
      m_ie = '0; m_rise = '0; m_fall = '0; m_lvl = '0; m_pend = '0;
      m_db = '0; m_p = '0; m_intr = 1'b0; m_cyc = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      ph.delete();
      repeat (SS) ph.push_back('0);
    end else begin
      s = ph[SS-1];
`ifdef EXTI_MC_DEBOUNCE_EN
      db = m_db;
`else
      db = s;
`endif
      rs  = (m_cyc >= ARM) ? (db & ~m_p) : '0;
      fl  = (m_cyc >= ARM) ? (~db & m_p) : '0;
      st  = (m_rise & rs) | (m_fall & fl) | (m_lvl & s);
      act = m_pend & m_ie;
      if (bus.valid && !bus.we) begin
        case (bus.addr[4:2])
          3'd0: rv = m_ie;
          3'd1: rv = m_rise;
          3'd2: rv = m_fall;
          3'd3: rv = m_lvl;
          3'd4: rv = m_pend;
          3'd5: rv = db;
          3'd6: rv = low_id(act);
          default: rv = '0;
        endcase
        e.val = fix_en ? fix_val : rv;
        e.off = int'(bus.addr[4:2]);
        e.tag = fix_en ? fix_tag : "rd";
        q.push_back(e);
      end
      w1c = '0;
      if (bus.valid && bus.we && bus.addr[4:2] == 3'd4) w1c = bus.wdata;
      m_intr = |act;
      m_pend = ((m_pend & ~w1c) | st) & MASK;
      if (bus.valid && bus.we) begin
        case (bus.addr[4:2])
          3'd0: m_ie   = bus.wdata & MASK;
          3'd1: m_rise = bus.wdata & MASK;
          3'd2: m_fall = bus.wdata & MASK;
          3'd3: m_lvl  = bus.wdata & MASK;
          default: ;
        endcase
      end
      m_p = db;
`ifdef EXTI_MC_DEBOUNCE_EN
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DL) begin
            m_db[i]  = s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`endif
      ph.push_front(32'(pins));
      void'(ph.pop_back());
      m_cyc++;
    end
  end

  initial begin : monitor
    exp_t e;
    wait (go);
    forever begin
      @(negedge clk);
      n_vec++;
      if (intr !== m_intr) begin
        n_bad++;
        $display("FAIL intr t=%0t: got %b want %b", $time, intr, m_intr);
      end
      if (bus.rvalid === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_rvalid t=%0t: got rvalid=1 want 0", $time);
        end else begin
          e = q.pop_front();
          if (bus.rdata !== e.val) begin
            n_bad++;
            $display("FAIL %s off=%0d t=%0t: got %h want %h",
                     e.tag, e.off, $time, bus.rdata, e.val);
          end
        end
      end else if (q.size() != 0) begin
        n_vec++;
        n_bad++;
        e = q.pop_front();
        $display("FAIL missing_rvalid %s t=%0t: got rvalid=%b want 1",
                 e.tag, $time, bus.rvalid);
      end
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [2:0] o, logic [31:0] d);
    bus.valid = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = {27'd0, o, 2'b00};
    bus.wdata = d;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.we    = 1'b0;
  endtask

  task automatic rd(logic [2:0] o, bit fx, logic [31:0] v, string tag);
    bus.valid = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = {27'd0, o, 2'b00};
    fix_en    = fx;
    fix_val   = v;
    fix_tag   = tag;
    @(negedge clk);
    bus.valid = 1'b0;
    fix_en    = 1'b0;
  endtask

  task automatic do_reset(logic [N-1:0] pv);
    rst_n = 1'b0;
    pins  = pv;
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int r;
    rst_n = 1'b0;
    pins = '0;
    bus.valid = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    fix_en = 1'b0;
    fix_val = '0;
    fix_tag = "";
    idle(3);
    go = 1'b1;
    chk("ready", 32'(bus.ready), 32'd1);
    rst_n = 1'b1;

    for (int o = 0; o < 8; o++) rd(3'(o), 1, 32'd0, "reset_reg");
    do_reset(12'h001);
    wr(3'd1, 32'h1);
    idle(12);
    rd(3'd4, 1, 32'h0, "prime_no_rise");
    rd(3'd5, 1, 32'h1, "raw_high");

    do_reset('0);
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h1);
    idle(3);
    pins[0] = 1'b1;
`ifdef EXTI_MC_DEBOUNCE_EN
    idle(12);
`else
    idle(2);
    rd(3'd4, 1, 32'h0, "pend_lat_early");
    chk("intr_lat_early", 32'(intr), 32'd0);
    rd(3'd4, 1, 32'h1, "pend_lat");
    chk("intr_lat", 32'(intr), 32'd1);
`endif
    rd(3'd4, 1, 32'h1, "edge_pend");
    rd(3'd6, 1, 32'd1, "edge_id");
    wr(3'd4, 32'h1);
    rd(3'd4, 1, 32'h0, "w1c_clear");
    idle(1);
    chk("intr_after_w1c", 32'(intr), 32'd0);

    do_reset('0);
    wr(3'd0, 32'hFFF);
    wr(3'd2, 32'h800);
    wr(3'd3, 32'h004);
    pins[11] = 1'b1;
    idle(12);
    pins[2] = 1'b1;
    pins[11] = 1'b0;
    idle(12);
    rd(3'd6, 1, 32'd3, "lvl_id");
    rd(3'd4, 1, 32'h804, "lvl_pend");
    wr(3'd4, 32'h004);
    idle(2);
    rd(3'd4, 1, 32'h804, "lvl_reset");
    pins[2] = 1'b0;
    idle(12);
    wr(3'd4, 32'h004);
    rd(3'd6, 1, 32'd12, "fall_id");

    do_reset('0);
    wr(3'd1, 32'h020);
    wr(3'd0, 32'h020);
    pins[5] = 1'b1;
    idle(12);
    pins[5] = 1'b0;
    idle(12);
    rd(3'd4, 1, 32'h020, "rise5");
    pins[5] = 1'b1;
    idle(LAT);
    wr(3'd4, 32'h020);
    rd(3'd4, 1, 32'h020, "set_wins");
    wr(3'd0, 32'h0);
    idle(2);
    rd(3'd6, 1, 32'd0, "masked_id");
    rd(3'd4, 1, 32'h020, "masked_pend");
    chk("masked_intr", 32'(intr), 32'd0);

    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 1, 32'hFFF, "ie_width");
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 1, 32'h0, "unmapped");

`ifdef EXTI_MC_DEBOUNCE_EN
    do_reset('0);
    wr(3'd1, 32'h002);
    idle(12);
    pins[1] = 1'b1;
    idle(3);
    pins[1] = 1'b0;
    idle(12);
    rd(3'd4, 1, 32'h0, "glitch");
    pins[1] = 1'b1;
    idle(6);
    pins[1] = 1'b0;
    idle(12);
    rd(3'd4, 1, 32'h002, "debounced_pulse");
`endif

    do_reset('0);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, N - 1));
        pins[r] = ~pins[r];
      end
      rst_n = ($urandom_range(0, 299) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 2) wr(3'($urandom_range(0, 3)), $urandom);
      else if (r == 2) wr(3'($urandom_range(0, 7)), $urandom);
      else if (r < 5) wr(3'd4, $urandom);
      else if (r < 8) rd(3'($urandom_range(0, 7)), 0, 32'd0, "");
      else idle(1);
    end
    rst_n = 1'b1;
    idle(3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
